// File: rtl/pwm_pkg.sv
// Shared PWM definitions: the capture FSM state type and the default
// measurement width, also used by the PWM generator.
package pwm_pkg;

   localparam int PWM_BITS_DEFAULT = 16;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      LOW       = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_sync_filter.sv
// Brings an asynchronous level into the clk domain through SYNC_STAGES flops.
// When PWM_CAPTURE_FILTER_EN is defined, a change is passed on only after
// the synchronized level has been stable for FILTER_LEN cycles.
module pwm_sync_filter
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1) begin : gBadParams
      $error("pwm_sync_filter: SYNC_STAGES must be 2..4 and FILTER_LEN at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   syncOut;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign syncOut = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int RunW = ($clog2(FILTER_LEN) > 0) ? $clog2(FILTER_LEN) : 1;

   logic [RunW-1:0] runCnt_q, runCnt_d;
   logic            clean_q, clean_d;

   // runCnt counts consecutive cycles the synchronized level has disagreed
   // with the accepted level; any agreement restarts the count.
   always_comb begin
      runCnt_d = '0;
      clean_d  = clean_q;
      if (syncOut != clean_q) begin
         if (runCnt_q == RunW'(FILTER_LEN - 1)) begin
            clean_d = syncOut;
         end else begin
            runCnt_d = runCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         runCnt_q <= '0;
         clean_q  <= 1'b0;
      end else begin
         runCnt_q <= runCnt_d;
         clean_q  <= clean_d;
      end
   end

   assign clean = clean_q;
`else
   assign clean = syncOut;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Define PWM_CAPTURE_FILTER_EN to insert the glitch filter before edge detection.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int PWM_BITS    = PWM_BITS_DEFAULT,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pwm_in,
   output logic [PWM_BITS-1:0] period,
   output logic [PWM_BITS-1:0] high_time,
   output logic                valid,
   output logic                stuck
);

   localparam logic [PWM_BITS-1:0] CntMax = '1;
   localparam logic [PWM_BITS-1:0] CntOne = PWM_BITS'(1);

   logic                pwmC, pwmCDly_q;
   logic                rise, fall, timeout;
   pwm_state_e          state_q, state_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
   logic [PWM_BITS-1:0] period_q, period_d, highTime_q, highTime_d;
   logic                valid_q, valid_d, stuck_q, stuck_d;

   pwm_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) uSyncFilter (
      .clk  (clk),
      .rst  (rst),
      .raw  (pwm_in),
      .clean(pwmC)
   );

   assign rise = pwmC & ~pwmCDly_q;
   assign fall = ~pwmC & pwmCDly_q;
   // A rise on the saturation cycle is a legal full-length period, so it masks the timeout.
   assign timeout = (cnt_q == CntMax) & ~rise & ~stuck_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_RISE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (rise) begin
         state_d = HIGH;
      end else if (timeout) begin
         state_d = WAIT_RISE;
      end else if (state_q == HIGH && fall) begin
         state_d = LOW;
      end
   end

   // Counters saturate instead of wrapping; only a rise in LOW closes a full period.
   always_comb begin
      cnt_d      = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      hcnt_d     = hcnt_q;
      period_d   = period_q;
      highTime_d = highTime_q;
      valid_d    = 1'b0;
      stuck_d    = stuck_q;
      if (state_q == HIGH && !fall && hcnt_q != CntMax) begin
         hcnt_d = hcnt_q + 1'b1;
      end
      if (rise) begin
         cnt_d   = CntOne;
         hcnt_d  = CntOne;
         stuck_d = 1'b0;
         if (state_q == LOW) begin
            period_d   = cnt_q;
            highTime_d = hcnt_q;
            valid_d    = 1'b1;
         end
      end else if (timeout) begin
         stuck_d    = 1'b1;
         period_d   = '0;
         highTime_d = pwmC ? CntMax : '0;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwmCDly_q  <= 1'b0;
         cnt_q      <= '0;
         hcnt_q     <= '0;
         period_q   <= '0;
         highTime_q <= '0;
         valid_q    <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         pwmCDly_q  <= pwmC;
         cnt_q      <= cnt_d;
         hcnt_q     <= hcnt_d;
         period_q   <= period_d;
         highTime_q <= highTime_d;
         valid_q    <= valid_d;
         stuck_q    <= stuck_d;
      end
   end

   assign period    = period_q;
   assign high_time = highTime_q;
   assign valid     = valid_q;
   assign stuck     = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized scoreboard bench for pwm_capture (PWM_BITS = 8); the reference
// model works from edge times and high-cycle tallies of the conditioned input.
module tb_pwm_capture;

   localparam int PWM_BITS    = 8;
   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 4;
   localparam int MAX_CNT     = (1 << PWM_BITS) - 1;

   typedef struct {
      logic [PWM_BITS-1:0] period;
      logic [PWM_BITS-1:0] highTime;
   } meas_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                pwm_in = 1'b0;
   logic [PWM_BITS-1:0] period;
   logic [PWM_BITS-1:0] high_time;
   logic                valid;
   logic                stuck;

   int    checks = 0;
   int    failures = 0;
   meas_t expQ[$];

   // Reference model state
   bit                  line[SYNC_STAGES];
   bit                  filt;
   int                  runLen;
   bit                  prevC;
   bit                  armed;
   bit                  expStuck;
   bit                  modelLive;
   int                  cycle;
   int                  lastRise;
   int                  lastRef;
   int                  highCount;
   logic [PWM_BITS-1:0] heldPeriod;
   logic [PWM_BITS-1:0] heldHigh;

   always #5 clk = ~clk;

   pwm_capture #(
      .PWM_BITS   (PWM_BITS),
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pwm_in   (pwm_in),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .stuck    (stuck)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
      end
   endtask

   task automatic applyStimulus(input logic level, input int cycles);
      pwm_in = level;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic applyReset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset period", 32'(period), 0);
      checkOutput("reset high_time", 32'(high_time), 0);
      checkOutput("reset valid", 32'(valid), 0);
      checkOutput("reset stuck", 32'(stuck), 0);
   endtask

   task automatic randomWaveform(input int periods);
      for (int p = 0; p < periods; p++) begin
         applyStimulus(1'b1, $urandom_range(1, 30));
         applyStimulus(1'b0, $urandom_range(1, 30));
      end
   endtask

   // Model: a measurement is the distance between consecutive rises of the
   // conditioned level plus the number of those cycles it spent high.
   always @(posedge clk) begin : model
      bit    c;
      bit    syncOut;
      bit    rise;
      int    elapsed;
      meas_t m;
      syncOut = line[SYNC_STAGES-1];
`ifdef PWM_CAPTURE_FILTER_EN
      c = filt;
`else
      c = syncOut;
`endif
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) line[i] = 1'b0;
         filt       = 1'b0;
         runLen     = 0;
         prevC      = 1'b0;
         armed      = 1'b0;
         expStuck   = 1'b0;
         highCount  = 0;
         lastRef    = cycle + 1;
         heldPeriod = '0;
         heldHigh   = '0;
      end else begin
         rise    = c && !prevC;
         elapsed = cycle - lastRef;
         if (rise) begin
            if (armed) begin
               m.period   = PWM_BITS'(cycle - lastRise);
               m.highTime = PWM_BITS'(highCount);
               expQ.push_back(m);
               heldPeriod = m.period;
               heldHigh   = m.highTime;
            end
            armed     = 1'b1;
            lastRise  = cycle;
            lastRef   = cycle;
            highCount = 1;
            expStuck  = 1'b0;
         end else begin
            if (elapsed >= MAX_CNT && !expStuck) begin
               m.period   = '0;
               m.highTime = c ? PWM_BITS'(MAX_CNT) : '0;
               expQ.push_back(m);
               heldPeriod = m.period;
               heldHigh   = m.highTime;
               expStuck   = 1'b1;
               armed      = 1'b0;
            end
            highCount += int'(c);
         end
         prevC = c;
         if (syncOut != filt) begin
            runLen++;
            if (runLen == FILTER_LEN) begin
               filt   = syncOut;
               runLen = 0;
            end
         end else begin
            runLen = 0;
         end
         for (int i = SYNC_STAGES - 1; i > 0; i--) line[i] = line[i-1];
         line[0] = pwm_in;
      end
      cycle++;
      modelLive = 1'b1;
   end

   // Monitor: every expected strobe must appear on the cycle it was predicted.
   always @(negedge clk) begin : monitor
      meas_t m;
      if (modelLive) begin
         if (expQ.size() > 0) begin
            m = expQ.pop_front();
            checkOutput("valid strobe", 32'(valid), 1);
            if (valid === 1'b1) begin
               checkOutput("strobe period", 32'(period), 32'(m.period));
               checkOutput("strobe high_time", 32'(high_time), 32'(m.highTime));
            end
         end else begin
            checkOutput("idle valid", 32'(valid), 0);
         end
         checkOutput("stuck flag", 32'(stuck), 32'(expStuck));
         checkOutput("held period", 32'(period), 32'(heldPeriod));
         checkOutput("held high_time", 32'(high_time), 32'(heldHigh));
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      pwm_in = 1'b0;
      @(negedge clk);
      applyReset(3);

`ifdef PWM_CAPTURE_FILTER_EN
      // High 20 / low 20 with short glitches that the filter must swallow
      for (int p = 0; p < 8; p++) begin
         int g1;
         int g2;
         g1 = $urandom_range(1, 3);
         g2 = $urandom_range(1, 3);
         applyStimulus(1'b1, 8);
         applyStimulus(1'b0, g1);
         applyStimulus(1'b1, 12 - g1);
         applyStimulus(1'b0, 9);
         applyStimulus(1'b1, g2);
         applyStimulus(1'b0, 11 - g2);
      end
      checkOutput("glitch period", 32'(period), 40);
      checkOutput("glitch high_time", 32'(high_time), 20);
`else
      for (int p = 0; p < 12; p++) begin
         applyStimulus(1'b1, 3);
         applyStimulus(1'b0, 5);
      end
      checkOutput("periodic period", 32'(period), 8);
      checkOutput("periodic high_time", 32'(high_time), 3);
`endif

      randomWaveform(25);

      // Rises exactly 2^PWM_BITS-1 cycles apart coincide with saturation
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 245);
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 245);
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 20);
      checkOutput("max period", 32'(period), MAX_CNT);
      checkOutput("max high_time", 32'(high_time), 10);
      checkOutput("max stuck", 32'(stuck), 0);

      applyReset(1);
      applyStimulus(1'b0, 300);
      checkOutput("low timeout period", 32'(period), 0);
      checkOutput("low timeout high_time", 32'(high_time), 0);
      checkOutput("low timeout stuck", 32'(stuck), 1);

      applyStimulus(1'b1, 300);
      checkOutput("high timeout period", 32'(period), 0);
      checkOutput("high timeout high_time", 32'(high_time), 32'hFF);
      checkOutput("high timeout stuck", 32'(stuck), 1);
      applyStimulus(1'b0, 10);

      for (int p = 0; p < 4; p++) begin
         applyStimulus(1'b1, 6);
         applyStimulus(1'b0, 6);
      end
      applyStimulus(1'b1, 3);
      applyReset(1);
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, 6);
      applyStimulus(1'b1, 6);
      applyStimulus(1'b0, 6);
      applyStimulus(1'b1, 6);
      applyStimulus(1'b0, 10);

      randomWaveform(25);
      applyStimulus(1'b0, 20);

      checkOutput("scoreboard drained", 32'(expQ.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
